// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA timing generator: pixel tick, h/v counters, phase FSMs, sync outputs
//
// Purpose: divides clk down to a pixel tick, scans h_cnt/v_cnt through the
// visible, front-porch, sync and back-porch phases, and decodes the pixel
// enable, coordinates, frame marker and active-low syncs.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-low reset
//   pxl_en      out  current pixel is visible (1 clk after counter state)
//   x           out  visible column, 0 outside the visible area
//   y           out  visible row (zero-extended), 0 outside the visible area
//   hsync       out  horizontal sync, active-low (2 clk after counter state)
//   vsync       out  vertical sync, active-low (2 clk after counter state)
//   frame_start out  one-clk pulse on the first clk of pixel (0,0)

module vga_sync_gen #(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic        clk,
   input  logic        rst,
   output logic        pxl_en,
   output logic [9:0]  x,
   output logic [10:0] y,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Last count of each phase; the FSM leaves a phase on the tick at its last count.
   localparam logic [9:0] H_ACT_END = 10'(H_VISIBLE - 1);
   localparam logic [9:0] H_FP_END  = 10'(H_VISIBLE + H_FRONT - 1);
   localparam logic [9:0] H_SYN_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_ACT_END = 10'(V_VISIBLE - 1);
   localparam logic [9:0] V_FP_END  = 10'(V_VISIBLE + V_FRONT - 1);
   localparam logic [9:0] V_SYN_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [3:0] DIV_LAST  = 4'(CLK_DIV - 1);

   typedef enum logic [1:0] {H_ACT, H_FP, H_SYN, H_BP} h_state_t;
   typedef enum logic [1:0] {V_ACT, V_FP, V_SYN, V_BP} v_state_t;

   logic [3:0] div_q, div_d;
   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   h_state_t   hst_q, hst_d;
   v_state_t   vst_q, vst_d;
   logic       tick, line_end, visible;

   logic        pxl_en_q, frame_start_q;
   logic [9:0]  x_q;
   logic [10:0] y_q;
   logic        hs_raw_q, vs_raw_q, hsync_q, vsync_q;

   always_comb begin
      tick     = (div_q == DIV_LAST);
      line_end = tick && (h_q == H_LAST);
      visible  = (hst_q == H_ACT) && (vst_q == V_ACT);

      div_d = tick ? 4'd0 : div_q + 4'd1;
      h_d   = h_q;
      hst_d = hst_q;
      v_d   = v_q;
      vst_d = vst_q;

      if (tick) begin
         h_d = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
         case (hst_q)
            H_ACT:   if (h_q == H_ACT_END) hst_d = H_FP;
            H_FP:    if (h_q == H_FP_END)  hst_d = H_SYN;
            H_SYN:   if (h_q == H_SYN_END) hst_d = H_BP;
            H_BP:    if (h_q == H_LAST)    hst_d = H_ACT;
            default: hst_d = H_ACT;
         endcase
      end

      // The vertical side only moves on the tick that closes a line.
      if (line_end) begin
         v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
         case (vst_q)
            V_ACT:   if (v_q == V_ACT_END) vst_d = V_FP;
            V_FP:    if (v_q == V_FP_END)  vst_d = V_SYN;
            V_SYN:   if (v_q == V_SYN_END) vst_d = V_BP;
            V_BP:    if (v_q == V_LAST)    vst_d = V_ACT;
            default: vst_d = V_ACT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         div_q         <= 4'd0;
         h_q           <= 10'd0;
         v_q           <= 10'd0;
         hst_q         <= H_ACT;
         vst_q         <= V_ACT;
         pxl_en_q      <= 1'b0;
         x_q           <= 10'd0;
         y_q           <= 11'd0;
         frame_start_q <= 1'b0;
         hs_raw_q      <= 1'b1;
         vs_raw_q      <= 1'b1;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
      end else begin
         div_q         <= div_d;
         h_q           <= h_d;
         v_q           <= v_d;
         hst_q         <= hst_d;
         vst_q         <= vst_d;
         pxl_en_q      <= visible;
         x_q           <= visible ? h_q : 10'd0;
         y_q           <= visible ? {1'b0, v_q} : 11'd0;
         frame_start_q <= (h_q == 10'd0) && (v_q == 10'd0) && (div_q == 4'd0);
         // Extra stage so sync lines up with the pixel generator's registered RGB.
         hs_raw_q      <= (hst_q != H_SYN);
         vs_raw_q      <= (vst_q != V_SYN);
         hsync_q       <= hs_raw_q;
         vsync_q       <= vs_raw_q;
      end
   end

   assign pxl_en      = pxl_en_q;
   assign x           = x_q;
   assign y           = y_q;
   assign frame_start = frame_start_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed checks of vga_sync_gen on reduced timings, CLK_DIV 2 and 1

module tb_vga_sync_gen;

   // Reduced timing: H 8/2/3/2 (total 15), V 4/1/2/1 (total 8).
   // A: CLK_DIV=2 -> line 30 clk, frame 240 clk. B: CLK_DIV=1 -> line 15, frame 120.
   logic clk = 1'b0;
   logic rst = 1'b0;

   logic        a_pxl, a_hs, a_vs, a_fs;
   logic [9:0]  a_x;
   logic [10:0] a_y;
   logic        b_pxl, b_hs, b_vs, b_fs;
   logic [9:0]  b_x;
   logic [10:0] b_y;

   vga_sync_gen #(
      .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
   ) dut_a (
      .clk(clk), .rst(rst), .pxl_en(a_pxl), .x(a_x), .y(a_y),
      .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs)
   );

   vga_sync_gen #(
      .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
   ) dut_b (
      .clk(clk), .rst(rst), .pxl_en(b_pxl), .x(b_x), .y(b_y),
      .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit sel;   // 0 = dut_a, 1 = dut_b
      int k;     // edges after the release edge (release edge is k=0)
      bit pxl;
      int x;
      int y;
      bit fs;
      bit hs;
      bit vs;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk_all(input bit sel, input string tag, input bit pxl, input int xv,
                          input int yv, input bit fs, input bit hs, input bit vs);
      if (!sel) begin
         chk({tag, " a.pxl_en"}, int'(a_pxl), int'(pxl));
         chk({tag, " a.x"}, int'(a_x), xv);
         chk({tag, " a.y"}, int'(a_y), yv);
         chk({tag, " a.frame_start"}, int'(a_fs), int'(fs));
         chk({tag, " a.hsync"}, int'(a_hs), int'(hs));
         chk({tag, " a.vsync"}, int'(a_vs), int'(vs));
      end else begin
         chk({tag, " b.pxl_en"}, int'(b_pxl), int'(pxl));
         chk({tag, " b.x"}, int'(b_x), xv);
         chk({tag, " b.y"}, int'(b_y), yv);
         chk({tag, " b.frame_start"}, int'(b_fs), int'(fs));
         chk({tag, " b.hsync"}, int'(b_hs), int'(hs));
         chk({tag, " b.vsync"}, int'(b_vs), int'(vs));
      end
   endtask

   initial begin
      int a_pxl_n, a_fs_n, a_hs_n, a_vs_n, a_ymax, a_xmax;
      int b_pxl_n, b_fs_n, b_hs_n, b_vs_n;

      //          sel  k   pxl x  y fs hs vs
      tbl.push_back('{0,   0, 1, 0, 0, 1, 1, 1});
      tbl.push_back('{1,   0, 1, 0, 0, 1, 1, 1});
      tbl.push_back('{0,   1, 1, 0, 0, 0, 1, 1});
      tbl.push_back('{1,   1, 1, 1, 0, 0, 1, 1});
      tbl.push_back('{0,   2, 1, 1, 0, 0, 1, 1});
      tbl.push_back('{1,   7, 1, 7, 0, 0, 1, 1});
      tbl.push_back('{1,   8, 0, 0, 0, 0, 1, 1});
      tbl.push_back('{1,  11, 0, 0, 0, 0, 0, 1});
      tbl.push_back('{1,  13, 0, 0, 0, 0, 0, 1});
      tbl.push_back('{1,  14, 0, 0, 0, 0, 1, 1});
      tbl.push_back('{0,  15, 1, 7, 0, 0, 1, 1});
      tbl.push_back('{1,  15, 1, 0, 1, 0, 1, 1});
      tbl.push_back('{0,  16, 0, 0, 0, 0, 1, 1});
      tbl.push_back('{0,  20, 0, 0, 0, 0, 1, 1});
      tbl.push_back('{0,  21, 0, 0, 0, 0, 0, 1});
      tbl.push_back('{0,  26, 0, 0, 0, 0, 0, 1});
      tbl.push_back('{0,  27, 0, 0, 0, 0, 1, 1});
      tbl.push_back('{0,  30, 1, 0, 1, 0, 1, 1});
      tbl.push_back('{0,  62, 1, 1, 2, 0, 1, 1});
      tbl.push_back('{1,  62, 0, 0, 0, 0, 1, 1});
      tbl.push_back('{1,  76, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{0,  95, 1, 2, 3, 0, 1, 1});
      tbl.push_back('{1, 105, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{1, 106, 0, 0, 0, 0, 1, 1});
      tbl.push_back('{0, 120, 0, 0, 0, 0, 1, 1});
      tbl.push_back('{1, 120, 1, 0, 0, 1, 1, 1});
      tbl.push_back('{0, 150, 0, 0, 0, 0, 1, 1});
      tbl.push_back('{0, 151, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{0, 210, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{0, 211, 0, 0, 0, 0, 1, 1});
      tbl.push_back('{0, 239, 0, 0, 0, 0, 1, 1});
      tbl.push_back('{0, 240, 1, 0, 0, 1, 1, 1});
      tbl.push_back('{1, 240, 1, 0, 0, 1, 1, 1});
      tbl.push_back('{0, 241, 1, 0, 0, 0, 1, 1});

      // Reset held for 5 clk: everything idle, syncs inactive.
      cyc = -100;
      repeat (5) step();
      chk_all(1'b0, "reset", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
      chk_all(1'b1, "reset", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);

      // Release; the next edge is k=0.
      rst = 1'b1;
      cyc = -1;
      foreach (tbl[i]) begin
         while (cyc < tbl[i].k) step();
         chk_all(tbl[i].sel, $sformatf("vec%0d", i), tbl[i].pxl, tbl[i].x, tbl[i].y,
                 tbl[i].fs, tbl[i].hs, tbl[i].vs);
      end

      // One A-frame (240 clk) of aggregate counts; the window is periodic so alignment is free.
      a_pxl_n = 0; a_fs_n = 0; a_hs_n = 0; a_vs_n = 0; a_ymax = 0; a_xmax = 0;
      b_pxl_n = 0; b_fs_n = 0; b_hs_n = 0; b_vs_n = 0;
      for (int i = 0; i < 240; i++) begin
         step();
         if (a_pxl) begin
            a_pxl_n++;
            if (int'(a_y) > a_ymax) a_ymax = int'(a_y);
            if (int'(a_x) > a_xmax) a_xmax = int'(a_x);
         end
         if (a_fs)  a_fs_n++;
         if (!a_hs) a_hs_n++;
         if (!a_vs) a_vs_n++;
         if (b_pxl) b_pxl_n++;
         if (b_fs)  b_fs_n++;
         if (!b_hs) b_hs_n++;
         if (!b_vs) b_vs_n++;
      end
      chk("frame a.pxl_en clks", a_pxl_n, 64);
      chk("frame a.frame_start pulses", a_fs_n, 1);
      chk("frame a.hsync low clks", a_hs_n, 48);
      chk("frame a.vsync low clks", a_vs_n, 60);
      chk("frame a.max y", a_ymax, 3);
      chk("frame a.max x", a_xmax, 7);
      chk("frame b.pxl_en clks", b_pxl_n, 64);
      chk("frame b.frame_start pulses", b_fs_n, 2);
      chk("frame b.hsync low clks", b_hs_n, 48);
      chk("frame b.vsync low clks", b_vs_n, 60);

      // Mid-frame reset while A shows pixel (3,1).
      for (int i = 0; i < 240 && (cyc % 240) != 36; i++) step();
      chk("pre-reset a.pxl_en", int'(a_pxl), 1);
      chk("pre-reset a.x", int'(a_x), 3);
      chk("pre-reset a.y", int'(a_y), 1);
      rst = 1'b0;
      step();
      chk_all(1'b0, "midreset", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
      chk_all(1'b1, "midreset", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
      rst = 1'b1;
      cyc = -1;
      step();
      chk_all(1'b0, "restart", 1'b1, 0, 0, 1'b1, 1'b1, 1'b1);
      chk_all(1'b1, "restart", 1'b1, 0, 0, 1'b1, 1'b1, 1'b1);
      while (cyc < 20) step();
      chk("restart a.hsync k20", int'(a_hs), 1);
      step();
      chk("restart a.hsync k21", int'(a_hs), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
